// File: rtl/median3x3_stream_filter.sv
// Full-frame 3x3 median filter with valid/ready streaming and end-of-frame flush.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start_i           arms one frame (only while idle)
//   in_valid_i/in_ready_o/in_pixel_i     input pixel stream, raster order
//   out_valid_o/out_ready_i/out_pixel_o  filtered pixel stream, raster order
//   done_o            one-cycle pulse after the last output handshake
module median3x3_stream_filter #(
  parameter int unsigned IMAGE_LEN    = 1080,
  parameter int unsigned IMAGE_HEIGHT = 720,
  parameter int unsigned NUM_CH       = 3,
  parameter int unsigned CH_W         = 8,
  parameter int unsigned BORDER_MODE  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [NUM_CH*CH_W-1:0] in_pixel_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [NUM_CH*CH_W-1:0] out_pixel_o,
  output logic                   done_o
);

  localparam int unsigned PW = NUM_CH * CH_W;
  localparam int unsigned XW = (IMAGE_LEN > 1) ? $clog2(IMAGE_LEN) : 1;
  localparam int unsigned YW = $clog2(IMAGE_HEIGHT + 2);
  localparam logic [XW-1:0] X_LAST      = XW'(IMAGE_LEN - 1);
  localparam logic [YW-1:0] Y_LAST      = YW'(IMAGE_HEIGHT - 1);
  localparam logic [YW-1:0] Y_FLUSH_END = YW'(IMAGE_HEIGHT + 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_FLUSH, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic [XW-1:0]     ix;
  logic [YW-1:0]     iy;
  logic [PW-1:0]     lb1 [IMAGE_LEN];
  logic [PW-1:0]     lb2 [IMAGE_LEN];
  logic [2:0][PW-1:0] h0, h1;
  logic [8:0][PW-1:0] win;
  logic              w_valid, w_last, w_border, o_last;

  logic              adv, cons, emit, flush_end;
  logic [PW-1:0]     push_pix;
  logic [2:0][PW-1:0] new_col;
  logic [2:0][2:0][PW-1:0] wcol;
  logic [XW-1:0]     ox;
  logic [YW-1:0]     oy;
  logic [8:0][PW-1:0] win_next;
  logic [8:0][CH_W-1:0] chv;
  logic [PW-1:0]     med;

  // Global stall: nothing moves while a held output is not accepted.
  assign adv        = !out_valid_o | out_ready_i;
  assign in_ready_o = (state == S_RUN) & adv;
  assign cons       = adv & (((state == S_RUN) & in_valid_i) | (state == S_FLUSH));
  assign flush_end  = (state == S_FLUSH) && (ix == '0) && (iy == Y_FLUSH_END);

  // 5th smallest of nine: the value whose rank range [lt, le-1] covers index 4.
  function automatic logic [CH_W-1:0] median9(input logic [8:0][CH_W-1:0] v);
    logic [CH_W-1:0] m;
    logic            found;
    int unsigned     lt, le;
    m     = '0;
    found = 1'b0;
    for (int i = 0; i < 9; i++) begin
      lt = 0;
      le = 0;
      for (int j = 0; j < 9; j++) begin
        if (v[j] <  v[i]) lt++;
        if (v[j] <= v[i]) le++;
      end
      if (!found && (lt <= 4) && (le >= 5)) begin
        m     = v[i];
        found = 1'b1;
      end
    end
    return m;
  endfunction

  // Window assembly: columns carry rows (oy-1, oy, oy+1); column and row edges are clamped.
  always_comb begin
    push_pix   = (state == S_RUN) ? in_pixel_i : '0;
    new_col[0] = lb2[ix];
    new_col[1] = lb1[ix];
    new_col[2] = push_pix;
    emit       = (iy != '0) && !((iy == YW'(1)) && (ix == '0));
    if (ix == '0) begin
      // Row wrap: the window of the previous row's last pixel uses only history columns.
      ox      = X_LAST;
      oy      = iy - YW'(2);
      wcol[0] = h1;
      wcol[1] = h0;
      wcol[2] = h0;
    end else begin
      ox      = ix - XW'(1);
      oy      = iy - YW'(1);
      wcol[0] = (ix == XW'(1)) ? h0 : h1;
      wcol[1] = h0;
      wcol[2] = new_col;
    end
    for (int c = 0; c < 3; c++) begin
      win_next[c]     = (oy == '0)    ? wcol[c][1] : wcol[c][0];
      win_next[3 + c] = wcol[c][1];
      win_next[6 + c] = (oy == Y_LAST) ? wcol[c][1] : wcol[c][2];
    end
  end

  // Per-channel median of the registered window.
  always_comb begin
    med = '0;
    chv = '0;
    for (int ch = 0; ch < int'(NUM_CH); ch++) begin
      for (int i = 0; i < 9; i++) chv[i] = win[i][ch*CH_W +: CH_W];
      med[ch*CH_W +: CH_W] = median9(chv);
    end
  end

  // Line buffers: rows y-1 and y-2 at the current column.
  always_ff @(posedge clk) begin
    if (cons) begin
      lb1[ix] <= push_pix;
      lb2[ix] <= lb1[ix];
    end
  end

  // Control FSM, counters and the two pipeline stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ix          <= '0;
      iy          <= '0;
      h0          <= '0;
      h1          <= '0;
      win         <= '0;
      w_valid     <= 1'b0;
      w_last      <= 1'b0;
      w_border    <= 1'b0;
      o_last      <= 1'b0;
      out_valid_o <= 1'b0;
      out_pixel_o <= '0;
      done_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE:  if (start_i) state <= S_RUN;
        S_RUN:   if (cons && (ix == X_LAST) && (iy == Y_LAST)) state <= S_FLUSH;
        S_FLUSH: if (cons && flush_end) state <= S_DRAIN;
        S_DRAIN: if (out_valid_o && out_ready_i && o_last) begin
          state  <= S_DONE;
          done_o <= 1'b1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (cons) begin
        h1 <= h0;
        h0 <= new_col;
        if (flush_end) begin
          ix <= '0;
          iy <= '0;
        end else if (ix == X_LAST) begin
          ix <= '0;
          iy <= iy + YW'(1);
        end else begin
          ix <= ix + XW'(1);
        end
      end

      if (adv) begin
        out_valid_o <= w_valid;
        o_last      <= w_valid & w_last;
        if (w_valid) out_pixel_o <= ((BORDER_MODE == 1) && w_border) ? win[4] : med;
        w_valid <= cons & emit;
        if (cons & emit) begin
          win      <= win_next;
          w_last   <= (ox == X_LAST) && (oy == Y_LAST);
          w_border <= (ox == '0) || (ox == X_LAST) || (oy == '0) || (oy == Y_LAST);
        end
      end
    end
  end

endmodule

// File: tb/tb_median3x3_stream_filter.sv
// Self-checking bench for median3x3_stream_filter: three instances (4x3 replicate,
// 4x3 pass-through borders, 8x6 replicate) driven from one stream, one active at a time.
module tb_median3x3_stream_filter;

  localparam int unsigned PW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    start;
  logic          in_valid, out_ready;
  logic [PW-1:0] in_pixel;
  logic          in_ready  [3];
  logic          out_valid [3];
  logic          done      [3];
  logic [PW-1:0] out_pixel [3];

  int unsigned   n_checks, n_fail;
  logic [PW-1:0] img     [48];
  logic [PW-1:0] obs     [48];
  logic [PW-1:0] ref_out [48];
  int            len, hgt, mode;

  always #5 clk = ~clk;

  median3x3_stream_filter #(.IMAGE_LEN(4), .IMAGE_HEIGHT(3), .NUM_CH(3), .CH_W(8), .BORDER_MODE(0)) dut_rep (
    .clk(clk), .rst_n(rst_n), .start_i(start[0]), .in_valid_i(in_valid), .in_ready_o(in_ready[0]),
    .in_pixel_i(in_pixel), .out_valid_o(out_valid[0]), .out_ready_i(out_ready),
    .out_pixel_o(out_pixel[0]), .done_o(done[0]));

  median3x3_stream_filter #(.IMAGE_LEN(4), .IMAGE_HEIGHT(3), .NUM_CH(3), .CH_W(8), .BORDER_MODE(1)) dut_pass (
    .clk(clk), .rst_n(rst_n), .start_i(start[1]), .in_valid_i(in_valid), .in_ready_o(in_ready[1]),
    .in_pixel_i(in_pixel), .out_valid_o(out_valid[1]), .out_ready_i(out_ready),
    .out_pixel_o(out_pixel[1]), .done_o(done[1]));

  median3x3_stream_filter #(.IMAGE_LEN(8), .IMAGE_HEIGHT(6), .NUM_CH(3), .CH_W(8), .BORDER_MODE(0)) dut_big (
    .clk(clk), .rst_n(rst_n), .start_i(start[2]), .in_valid_i(in_valid), .in_ready_o(in_ready[2]),
    .in_pixel_i(in_pixel), .out_valid_o(out_valid[2]), .out_ready_i(out_ready),
    .out_pixel_o(out_pixel[2]), .done_o(done[2]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // Reference: gather the clamped 3x3 neighbourhood, sort each channel, take the middle.
  function automatic logic [PW-1:0] model_px(input int x, input int y);
    logic [PW-1:0] res;
    logic [PW-1:0] p;
    int            v [9];
    int            k, t;
    if ((mode == 1) && ((x == 0) || (x == len - 1) || (y == 0) || (y == hgt - 1)))
      return img[y * len + x];
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      k = 0;
      for (int dy = -1; dy <= 1; dy++) begin
        for (int dx = -1; dx <= 1; dx++) begin
          p    = img[clampi(y + dy, hgt - 1) * len + clampi(x + dx, len - 1)];
          v[k] = int'(p[ch*8 +: 8]);
          k++;
        end
      end
      for (int i = 1; i < 9; i++) begin
        for (int j = i; j > 0 && v[j-1] > v[j]; j--) begin
          t = v[j]; v[j] = v[j-1]; v[j-1] = t;
        end
      end
      res[ch*8 +: 8] = 8'(v[4]);
    end
    return res;
  endfunction

  task automatic check_reset_state(input int s);
    check_eq("rst_in_ready",  32'(in_ready[s]),  0);
    check_eq("rst_out_valid", 32'(out_valid[s]), 0);
    check_eq("rst_done",      32'(done[s]),      0);
    check_eq("rst_out_pixel", 32'(out_pixel[s]), 0);
  endtask

  // Streams img through instance s; abort_after>0 resets the design after that many inputs.
  task automatic run_frame(input int s, input int gap_pct, input int stall_pct,
                           input bit poke_start, input int abort_after);
    int            total, in_idx, out_idx, done_cnt;
    bit            hold, in_hs, out_hs;
    logic [PW-1:0] held_px;
    len   = (s == 2) ? 8 : 4;
    hgt   = (s == 2) ? 6 : 3;
    mode  = (s == 1) ? 1 : 0;
    total = len * hgt;
    in_idx = 0; out_idx = 0; done_cnt = 0; hold = 1'b0; held_px = '0;
    @(negedge clk); start[s] = 1'b1;
    @(negedge clk); start[s] = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      out_ready = ($urandom_range(99) >= stall_pct);
      in_valid  = (in_idx < total) && ($urandom_range(99) >= gap_pct);
      in_pixel  = (in_idx < total) ? img[in_idx] : PW'($urandom);
      start[s]  = poke_start && (cyc == 7);
      #1;
      if (hold) begin
        check_eq("stall_valid", 32'(out_valid[s]), 1);
        check_eq("stall_pixel", 32'(out_pixel[s]), 32'(held_px));
      end
      if (done[s]) begin
        check_eq("done_after_last", 32'(out_idx), 32'(total));
        done_cnt++;
      end
      if ((done_cnt > 0) && !done[s]) break;
      in_hs  = in_valid && in_ready[s];
      out_hs = out_valid[s] && out_ready;
      if (out_hs) begin
        if (out_idx < total) begin
          obs[out_idx] = out_pixel[s];
          check_eq($sformatf("pix_s%0d_x%0d_y%0d", s, out_idx % len, out_idx / len),
                   32'(out_pixel[s]), 32'(model_px(out_idx % len, out_idx / len)));
        end else begin
          check_eq("extra_output", 32'(out_idx + 1), 32'(total));
        end
        out_idx++;
      end
      hold    = out_valid[s] && !out_ready;
      held_px = out_pixel[s];
      if (in_hs) in_idx++;
      if ((abort_after > 0) && (in_idx == abort_after)) begin
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_reset_state(s);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        return;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    start[s]  = 1'b0;
    check_eq("done_count", 32'(done_cnt), 1);
    check_eq("out_count",  32'(out_idx), 32'(total));
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; start = '0; in_valid = 1'b0; out_ready = 1'b1; in_pixel = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_state(0);
    @(negedge clk);
    rst_n = 1'b1;

    // Flat field stays flat.
    for (int i = 0; i < 12; i++) img[i] = 24'h102030;
    run_frame(0, 0, 0, 1'b0, 0);
    check_eq("flat_first", 32'(obs[0]),  32'h102030);
    check_eq("flat_last",  32'(obs[11]), 32'h102030);

    // Raster ramp on channel 0.
    for (int i = 0; i < 12; i++) img[i] = 24'(i);
    run_frame(0, 0, 0, 1'b0, 0);
    check_eq("ramp_0_0", 32'(obs[0]),  1);
    check_eq("ramp_1_1", 32'(obs[5]),  5);
    check_eq("ramp_3_2", 32'(obs[11]), 10);

    // Single bright pixel is removed in both border modes.
    for (int i = 0; i < 12; i++) img[i] = '0;
    img[6] = 24'hFFFFFF;
    run_frame(0, 0, 0, 1'b0, 0);
    check_eq("impulse_rep_2_1", 32'(obs[6]), 0);
    run_frame(1, 0, 0, 1'b0, 0);
    check_eq("impulse_pass_1_1", 32'(obs[5]), 0);
    check_eq("impulse_pass_2_1", 32'(obs[6]), 0);

    // Random 8x6: free-running, then with gaps, backpressure and a stray start.
    for (int i = 0; i < 48; i++) img[i] = PW'($urandom);
    run_frame(2, 0, 0, 1'b0, 0);
    for (int i = 0; i < 48; i++) ref_out[i] = obs[i];
    run_frame(2, 30, 50, 1'b1, 0);
    for (int i = 0; i < 48; i++) check_eq($sformatf("stall_vs_free_%0d", i), 32'(obs[i]), 32'(ref_out[i]));

    // Random 4x3 with pass-through borders under stalls.
    for (int i = 0; i < 12; i++) img[i] = PW'($urandom);
    run_frame(1, 25, 50, 1'b1, 0);

    // Reset mid-frame, then a complete frame.
    for (int i = 0; i < 12; i++) img[i] = PW'($urandom);
    run_frame(0, 0, 0, 1'b0, 5);
    run_frame(0, 20, 40, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
